// File: rtl/multicycle_subtractor_pkg.sv
// Shared definitions for the multicycle subtractor: FSM state encoding and
// the helper that sizes the slice counter.
package multicycle_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to count n slices; never narrower than one bit so NSLICE=1 still works
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multicycle_subtractor_if.sv
// Start/busy/done handshake and result bus of the multicycle subtractor.
interface multicycle_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, x, y, bin,
        input  busy, done, d, bout, overflow, zero
    );

    modport slave (
        input  start, x, y, bin,
        output busy, done, d, bout, overflow, zero
    );
endinterface

// File: rtl/multicycle_subtractor_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: {bo, diff} = a - b - bi.
module subtractor_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bi,
    output logic [SLICE-1:0] diff,
    output logic             bo
);
    logic [SLICE:0] t;

    // A negative result in SLICE+1 bits shows up as a set top bit, which is the borrow
    assign t    = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};
    assign diff = t[SLICE-1:0];
    assign bo   = t[SLICE];
endmodule

// File: rtl/multicycle_subtractor.sv
// N-bit subtractor that processes one SLICE-bit chunk per clock, LSB first,
// carrying the borrow between cycles in a register.
module multicycle_subtractor
    import multicycle_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_subtractor_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             breg;
    logic [SLICE-1:0] xs;
    logic [SLICE-1:0] ys;
    logic [SLICE-1:0] s;
    logic             bo;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             ovf_r;
    logic             zero_r;

    assign xs = xr[cnt*SLICE +: SLICE];
    assign ys = yr[cnt*SLICE +: SLICE];

    subtractor_slice #(.SLICE(SLICE)) u_slice (
        .a    (xs),
        .b    (ys),
        .bi   (breg),
        .diff (s),
        .bo   (bo)
    );

    // Accumulator with the current slice already merged, so the final cycle can publish it directly
    always_comb begin
        acc_next = acc;
        acc_next[cnt*SLICE +: SLICE] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            xr     <= '0;
            yr     <= '0;
            acc    <= '0;
            breg   <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc  <= acc_next;
                    breg <= bo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        d_r    <= acc_next;
                        bout_r <= bo;
                        ovf_r  <= (xr[WIDTH-1] ^ yr[WIDTH-1]) & (acc_next[WIDTH-1] ^ xr[WIDTH-1]);
                        zero_r <= ~|acc_next;
                        state  <= ST_DONE;
                    end
                end
                // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise
                default: begin
                    if (bus.start) begin
                        xr    <= bus.x;
                        yr    <= bus.y;
                        breg  <= bus.bin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.d        = d_r;
    assign bus.bout     = bout_r;
    assign bus.overflow = ovf_r;
    assign bus.zero     = zero_r;
endmodule

// File: tb/tb_multicycle_subtractor.sv
// Self-checking bench: table vectors and random operands through a scoreboard,
// plus hand sequences for handshake, back-to-back and reset-abort cases.
module tb_multicycle_subtractor;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        exp_t        e;
    } vec_t;

    logic clk;
    logic rst;
    int   tot;
    int   bad;
    exp_t q16[$];
    exp_t q4[$];
    vec_t vecs[9];

    multicycle_subtractor_if #(.WIDTH(16)) bus16 ();
    multicycle_subtractor_if #(.WIDTH(4))  bus4 ();

    multicycle_subtractor #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    multicycle_subtractor #(.WIDTH(4), .SLICE(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot = tot + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv, input logic bv);
        logic [16:0] t;
        exp_t        r;
        t      = {1'b0, xv} - {1'b0, yv} - {16'd0, bv};
        r.d    = t[15:0];
        r.bout = t[16];
        r.ovf  = (xv[15] ^ yv[15]) & (t[15] ^ xv[15]);
        r.zero = (t[15:0] == 16'd0);
        return r;
    endfunction

    // Scoreboard: every done pulse pops and compares the oldest expected result
    always @(negedge clk) begin
        if (bus16.done) begin
            if (q16.size() == 0) begin
                checkOutput("unexpected_done16", 32'(bus16.done), 32'd0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                checkOutput("d16", 32'(bus16.d), 32'(e.d));
                checkOutput("bout16", 32'(bus16.bout), 32'(e.bout));
                checkOutput("ovf16", 32'(bus16.overflow), 32'(e.ovf));
                checkOutput("zero16", 32'(bus16.zero), 32'(e.zero));
                checkOutput("busy_at_done16", 32'(bus16.busy), 32'd0);
            end
        end
        if (bus4.done) begin
            if (q4.size() == 0) begin
                checkOutput("unexpected_done4", 32'(bus4.done), 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                checkOutput("d4", 32'(bus4.d), 32'(e.d));
                checkOutput("bout4", 32'(bus4.bout), 32'(e.bout));
                checkOutput("ovf4", 32'(bus4.overflow), 32'(e.ovf));
                checkOutput("zero4", 32'(bus4.zero), 32'(e.zero));
            end
        end
    end

    task automatic waitDone16(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus16.done) begin
                n = i;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tot = tot + 1;
            bad = bad + 1;
            $display("[TB] FAIL timeout16: got no done expected done within 30 cycles");
            q16.delete();
        end
    endtask

    task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv, input logic bv, input exp_t e);
        int lat;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.x     = xv;
        bus16.y     = yv;
        bus16.bin   = bv;
        q16.push_back(e);
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.x     = 16'($urandom);
        bus16.y     = 16'($urandom);
        bus16.bin   = 1'($urandom);
        checkOutput("busy_run", 32'(bus16.busy), 32'd1);
        waitDone16(lat);
        checkOutput("latency", 32'(lat), 32'd4);
    endtask

    initial begin
        int   lat;
        int   t1;
        int   t2;
        int   npulse;
        exp_t ea;
        exp_t eb;
        logic [15:0] xv;
        logic [15:0] yv;
        logic        bv;

        tot = 0;
        bad = 0;
        vecs[0] = '{x:16'h1234, y:16'h0235, bin:1'b0, e:'{d:16'h0FFF, bout:1'b0, ovf:1'b0, zero:1'b0}};
        vecs[1] = '{x:16'h0000, y:16'h0001, bin:1'b0, e:'{d:16'hFFFF, bout:1'b1, ovf:1'b0, zero:1'b0}};
        vecs[2] = '{x:16'h8000, y:16'h0001, bin:1'b0, e:'{d:16'h7FFF, bout:1'b0, ovf:1'b1, zero:1'b0}};
        vecs[3] = '{x:16'hABCD, y:16'hABCD, bin:1'b0, e:'{d:16'h0000, bout:1'b0, ovf:1'b0, zero:1'b1}};
        vecs[4] = '{x:16'h0005, y:16'h0003, bin:1'b1, e:'{d:16'h0001, bout:1'b0, ovf:1'b0, zero:1'b0}};
        vecs[5] = '{x:16'h0000, y:16'h0000, bin:1'b1, e:'{d:16'hFFFF, bout:1'b1, ovf:1'b0, zero:1'b0}};
        vecs[6] = '{x:16'h7FFF, y:16'hFFFF, bin:1'b0, e:'{d:16'h8000, bout:1'b1, ovf:1'b1, zero:1'b0}};
        vecs[7] = '{x:16'hFFFF, y:16'hFFFF, bin:1'b1, e:'{d:16'hFFFF, bout:1'b1, ovf:1'b0, zero:1'b0}};
        vecs[8] = '{x:16'h0001, y:16'h0000, bin:1'b1, e:'{d:16'h0000, bout:1'b0, ovf:1'b0, zero:1'b1}};

        rst = 1'b1;
        bus16.start = 1'b0; bus16.x = '0; bus16.y = '0; bus16.bin = 1'b0;
        bus4.start  = 1'b0; bus4.x  = '0; bus4.y  = '0; bus4.bin  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(bus16.busy), 32'd0);
        checkOutput("rst_done", 32'(bus16.done), 32'd0);
        checkOutput("rst_d", 32'(bus16.d), 32'd0);
        checkOutput("rst_flags", 32'({bus16.bout, bus16.overflow, bus16.zero}), 32'd0);
        rst = 1'b0;

        // Narrow instance: one bit per clock, four RUN cycles
        @(negedge clk);
        bus4.start = 1'b1; bus4.x = 4'b1010; bus4.y = 4'b0101; bus4.bin = 1'b0;
        q4.push_back('{d:16'h0005, bout:1'b0, ovf:1'b1, zero:1'b0});
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus4.done) begin
                lat = i;
                break;
            end
        end
        checkOutput("latency4", 32'(lat), 32'd4);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].bin, vecs[i].e);
        end

        // Outputs hold after completion
        @(negedge clk);
        checkOutput("hold_d", 32'(bus16.d), 32'h0000);
        checkOutput("hold_zero", 32'(bus16.zero), 32'd1);
        checkOutput("hold_done", 32'(bus16.done), 32'd0);

        for (int i = 0; i < 6; i++) begin
            xv = 16'($urandom);
            yv = 16'($urandom);
            bv = 1'($urandom);
            applyStimulus(xv, yv, bv, model(xv, yv, bv));
        end

        // start pulsed during RUN must be ignored
        @(negedge clk);
        bus16.start = 1'b1; bus16.x = 16'h1234; bus16.y = 16'h0235; bus16.bin = 1'b0;
        q16.push_back(model(16'h1234, 16'h0235, 1'b0));
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        bus16.start = 1'b1; bus16.x = 16'hFFFF; bus16.y = 16'h0000;
        @(negedge clk);
        bus16.start = 1'b0;
        waitDone16(lat);
        checkOutput("latency_ignored", 32'(lat), 32'd2);
        repeat (8) @(negedge clk);
        checkOutput("idle_after_ignore", 32'(bus16.busy), 32'd0);

        // start held through DONE: back-to-back operations
        ea = model(16'h0F0F, 16'h00F0, 1'b0);
        eb = model(16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        bus16.start = 1'b1; bus16.x = 16'h0F0F; bus16.y = 16'h00F0; bus16.bin = 1'b0;
        q16.push_back(ea);
        @(negedge clk);
        bus16.x = 16'h0001; bus16.y = 16'h0002;
        q16.push_back(eb);
        t1 = 0; t2 = 0; npulse = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus16.done) begin
                npulse = npulse + 1;
                if (t1 == 0) t1 = i;
                else t2 = i;
            end else if (t1 != 0) begin
                bus16.start = 1'b0;
            end
        end
        bus16.start = 1'b0;
        checkOutput("b2b_pulses", 32'(npulse), 32'd2);
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'd5);

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        bus16.start = 1'b1; bus16.x = 16'h5555; bus16.y = 16'h1111; bus16.bin = 1'b0;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus16.busy), 32'd0);
        checkOutput("abort_d", 32'(bus16.d), 32'd0);
        checkOutput("abort_done", 32'(bus16.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(16'h5555, 16'h1111, 1'b0, '{d:16'h4444, bout:1'b0, ovf:1'b0, zero:1'b0});

        repeat (3) @(negedge clk);
        checkOutput("leftover16", 32'(q16.size()), 32'd0);
        checkOutput("leftover4", 32'(q4.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_subtractor.md
Name: multicycle_subtractor

Overview:
Parametrised N-bit subtractor that computes X − Y − Bin one SLICE-bit chunk per clock, LSB first, with a ripple borrow held in a register between cycles. It replaces the fixed 4-bit combinational subtractor wherever wide operands must be subtracted at low gate cost. It uses a start/busy/done handshake, registered results, a borrow-out flag and signed-overflow and zero flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock; 1 ≤ SLICE ≤ WIDTH.
- NSLICE (localparam), WIDTH/SLICE, number of compute cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- x  in  WIDTH  minuend; captured on accepted start
- y  in  WIDTH  subtrahend; captured on accepted start
- bin  in  1  borrow-in; captured on accepted start
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when the result is loaded
- d  out  WIDTH  difference (X − Y − Bin) mod 2^WIDTH
- bout  out  1  final borrow-out; 1 when X < Y + Bin (unsigned)
- overflow  out  1  two's-complement overflow
- zero  out  1  d == 0

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, d=0, bout=0, overflow=0, zero=0. Operand registers, slice counter and borrow register are cleared.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch x, y and bin, set cnt=0, go to RUN.
  - RUN: busy=1. Each cycle, for slice cnt: {b, s} = xr[slice] − yr[slice] − breg. Write s into the accumulator slice and set breg ← b. cnt increments. When cnt = NSLICE−1, load d, bout, overflow and zero from the final values and go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. If start=1 in this cycle, the new operation is accepted and the next state is RUN. Otherwise go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+NSLICE. Back-to-back throughput is one result every NSLICE+1 cycles.
- start while busy=1 is ignored, with no queuing. Inputs x, y and bin may change freely after acceptance.
- Outputs d, bout, overflow and zero change only at completion. They hold their values through IDLE and the next RUN until the next completion.
- overflow = (xr[MSB] ≠ yr[MSB]) & (d[MSB] ≠ xr[MSB]).
- zero = ~|d. It is independent of bout.
- Arithmetic is modulo 2^WIDTH and all widths are exact, so there is no extension beyond WIDTH.
- Reset mid-RUN aborts immediately. The partial result is discarded, outputs go to reset values, and done is not pulsed.
- NSLICE=1 is legal: one RUN cycle, then DONE.

Decomposition:
- Package multicycle_subtractor_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter-width function clog2(NSLICE), with a minimum of 1.
- Sub-module subtractor_slice: a combinational SLICE-bit ripple-borrow subtractor with ports a, b, bi → diff, bo.
  - The top level instantiates it once and muxes slices by cnt. Shifting operand registers is also acceptable.

Test Plan:
1. WIDTH=4, SLICE=1: x=1010, y=0101, bin=0 → after 4 cycles done=1, d=0101, bout=0, overflow=1 (−6−5), zero=0.
2. Default parameters: x=0x1234, y=0x0235, bin=0 → done at start+4 edges, d=0x0FFF, bout=0, overflow=0. Then x=0x0000, y=0x0001 → d=0xFFFF, bout=1, overflow=0.
3. Signed overflow and zero: x=0x8000, y=0x0001 → d=0x7FFF, overflow=1, bout=0. Then x=y=0xABCD → d=0, zero=1, bout=0.
4. Borrow-in: x=0x0005, y=0x0003, bin=1 → d=0x0001. x=0x0000, y=0x0000, bin=1 → d=0xFFFF, bout=1.
5. Handshake:
   - start pulsed again during RUN is ignored; d matches the first operands.
   - start held high through DONE → the second operation is accepted and the two done pulses are exactly 5 cycles apart.
6. Reset mid-RUN: assert rst at cycle 2 of RUN → busy=0 and d=0 immediately, with no done pulse. After release, a fresh start produces a correct result.
